clawgame_scoreboard: RTL and testbench

//  Parametrised game controller and display driver for the claw game, replacing the fixed score/display logic.
//  - Runs the round state machine: countdown timer plus BCD score counter driven by the prize sensor.
//  - Time-multiplexes NUM_DIGITS seven-segment digits (score right-aligned, timer left-aligned).
//  - Sits between the sensor/button inputs and the board's anode/segment pins.

---
 rtl/clawgame_pkg.sv | 36 +++
 rtl/seg7_decoder.sv | 26 ++
 rtl/clawgame_scoreboard.sv | 196 +++++++++++++++++++
 tb/tb_clawgame_scoreboard.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clawgame_pkg.sv
// Shared definitions for the claw game scoreboard: FSM encoding, BCD digit type
// and the active-low seven-segment patterns {dp,g,f,e,d,c,b,a}.
package clawgame_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PLAYING   = 2'd1;
    localparam logic [1:0] ST_GAME_OVER = 2'd2;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;

    // Packs an integer into up to eight BCD digits, least significant digit in [3:0].
    function automatic logic [31:0] to_bcd(input int unsigned value);
        int unsigned v;
        logic [31:0] res;
        v   = value;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            res[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder; non-decimal codes blank the digit.
module seg7_decoder
    import clawgame_pkg::*;
(
    input  bcd_digit_t  digit,
    output logic [7:0]  seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (digit)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/clawgame_scoreboard.sv
// Claw game round controller: countdown timer, BCD score and multiplexed 7-segment display.
// Optional CLAWGAME_HIGH_SCORE_EN keeps a high score that the IDLE display shows.
module clawgame_scoreboard
    import clawgame_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SCORE_DIGITS = 4,
    parameter int unsigned TIMER_DIGITS = 2,
    parameter int unsigned GAME_SECONDS = 60,
    parameter int unsigned TICK_DIV     = 100000000,
    parameter int unsigned REFRESH_DIV  = 100000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  increment_score,
    input  logic                  start_game,
    output logic [NUM_DIGITS-1:0] anode_activate,
    output logic [7:0]            LED_out,
    output logic                  game_active
);

    localparam int unsigned TIMER_W    = TIMER_DIGITS * 4;
    localparam int unsigned TIMER_BASE = NUM_DIGITS - TIMER_DIGITS;
    localparam int unsigned TICK_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned REFRESH_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(to_bcd(GAME_SECONDS));

    logic [1:0]                     state_q, state_next_c;
    bcd_digit_t [SCORE_DIGITS-1:0]  score_q, score_inc_c, shown_score_c;
    bcd_digit_t [TIMER_DIGITS-1:0]  timer_q, timer_dec_c;
    logic [TICK_W-1:0]              tick_q;
    logic [REFRESH_W-1:0]           refresh_q;
    logic [IDX_W-1:0]               digit_idx_q;
    logic                           inc_meta_q, inc_sync_q, inc_prev_q, inc_rise_c;
    logic                           playing_c, tick_wrap_c, start_c, expire_c, score_full_c;
    logic [NUM_DIGITS-1:0][4:0]     pos_val_c;
    logic [4:0]                     sel_c;
    logic [7:0]                     seg_c, led_c;

    // Prize sensor synchroniser and rising-edge detect
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inc_meta_q <= 1'b0;
            inc_sync_q <= 1'b0;
            inc_prev_q <= 1'b0;
        end else begin
            inc_meta_q <= increment_score;
            inc_sync_q <= inc_meta_q;
            inc_prev_q <= inc_sync_q;
        end
    end

    assign inc_rise_c  = inc_sync_q & ~inc_prev_q;
    assign playing_c   = (state_q == ST_PLAYING);
    assign tick_wrap_c = playing_c && (tick_q == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_next_c;
    end

    always_comb begin
        state_next_c = state_q;
        start_c      = 1'b0;
        expire_c     = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_game) begin
                    start_c      = 1'b1;
                    state_next_c = ST_PLAYING;
                end
            end
            ST_PLAYING: begin
                if (tick_wrap_c && (timer_q == TIMER_W'(1))) begin
                    expire_c     = 1'b1;
                    state_next_c = ST_GAME_OVER;
                end
            end
            default: state_next_c = ST_IDLE;
        endcase
    end

    // Saturating BCD increment of the score
    always_comb begin : score_incr
        logic carry;
        carry        = 1'b1;
        score_full_c = 1'b1;
        score_inc_c  = score_q;
        for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
            score_full_c = score_full_c & (score_q[i] == 4'd9);
            if (carry) begin
                if (score_q[i] == 4'd9) begin
                    score_inc_c[i] = 4'd0;
                end else begin
                    score_inc_c[i] = score_q[i] + 4'd1;
                    carry          = 1'b0;
                end
            end
        end
    end

    always_comb begin : timer_decr
        logic borrow;
        borrow      = 1'b1;
        timer_dec_c = timer_q;
        for (int i = 0; i < int'(TIMER_DIGITS); i++) begin
            if (borrow) begin
                if (timer_q[i] == 4'd0) begin
                    timer_dec_c[i] = 4'd9;
                end else begin
                    timer_dec_c[i] = timer_q[i] - 4'd1;
                    borrow         = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            score_q     <= '0;
            timer_q     <= TIMER_INIT;
            tick_q      <= '0;
            game_active <= 1'b0;
        end else begin
            game_active <= (state_next_c == ST_PLAYING);
            if (start_c) score_q <= '0;
            else if (playing_c && inc_rise_c && !score_full_c) score_q <= score_inc_c;
            if (start_c) timer_q <= TIMER_INIT;
            else if (tick_wrap_c) timer_q <= timer_dec_c;
            if (!playing_c || tick_wrap_c) tick_q <= '0;
            else tick_q <= tick_q + TICK_W'(1);
        end
    end

`ifdef CLAWGAME_HIGH_SCORE_EN
    bcd_digit_t [SCORE_DIGITS-1:0] high_score_q, score_final_c;

    // Include a point landing on the expiry edge in the comparison
    assign score_final_c = (inc_rise_c && !score_full_c) ? score_inc_c : score_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) high_score_q <= '0;
        else if (expire_c && (score_final_c > high_score_q)) high_score_q <= score_final_c;
    end

    assign shown_score_c = (state_q == ST_IDLE) ? high_score_q : score_q;
`else
    assign shown_score_c = score_q;
`endif

    // Per-position content: {blank, bcd}; the timer field wins where fields overlap
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_pos
        if (g >= TIMER_BASE) begin : g_timer
            assign pos_val_c[g] = {1'b0, timer_q[g - TIMER_BASE]};
        end else if (g < SCORE_DIGITS) begin : g_score
            assign pos_val_c[g] = {1'b0, shown_score_c[g]};
        end else begin : g_blank
            assign pos_val_c[g] = 5'h10;
        end
    end

    always_comb begin
        sel_c = 5'h10;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (digit_idx_q == IDX_W'(i)) sel_c = pos_val_c[i];
        end
    end

    seg7_decoder u_seg7_decoder (
        .digit (sel_c[3:0]),
        .seg_c (seg_c)
    );

    assign led_c = sel_c[4] ? SEG_BLANK : seg_c;

    // Anode and segments update from the same digit index on the same edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            refresh_q      <= '0;
            digit_idx_q    <= '0;
            anode_activate <= ~NUM_DIGITS'(1);
            LED_out        <= SEG_BLANK;
        end else begin
            anode_activate <= ~(NUM_DIGITS'(1) << digit_idx_q);
            LED_out        <= led_c;
            if (refresh_q == REFRESH_W'(REFRESH_DIV - 1)) begin
                refresh_q   <= '0;
                digit_idx_q <= (digit_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx_q + IDX_W'(1);
            end else begin
                refresh_q <= refresh_q + REFRESH_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_clawgame_scoreboard.sv
// Self-checking bench for clawgame_scoreboard against an integer-level round/display model.
module tb_clawgame_scoreboard;

    localparam int ND = 8, SD = 4, TD = 2, GS = 3, TDIV = 10, RDIV = 4;
    localparam int SAT_GS = 99, SAT_TDIV = 250;
`ifdef CLAWGAME_HIGH_SCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif
    localparam int M_IDLE = 0, M_PLAY = 1, M_OVER = 2;
    localparam logic [7:0] SEG_TB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          increment_score = 1'b0, start_game = 1'b0;
    logic [ND-1:0] anode_activate;
    logic [7:0]    LED_out;
    logic          game_active;
    logic          sat_inc = 1'b0, sat_start = 1'b0;
    logic [ND-1:0] sat_anode;
    logic [7:0]    sat_led;
    logic          sat_active;

    int checks = 0, errors = 0;
    int m_state, m_score, m_timer, m_tick, m_high, m_edges;
    bit h0, h1, h2;
    logic [7:0] disp [ND];

    always #5 clock = ~clock;

    clawgame_scoreboard #(.NUM_DIGITS(ND), .SCORE_DIGITS(SD), .TIMER_DIGITS(TD),
        .GAME_SECONDS(GS), .TICK_DIV(TDIV), .REFRESH_DIV(RDIV)) dut (
        .clock(clock), .reset(reset), .increment_score(increment_score),
        .start_game(start_game), .anode_activate(anode_activate),
        .LED_out(LED_out), .game_active(game_active));

    clawgame_scoreboard #(.NUM_DIGITS(ND), .SCORE_DIGITS(SD), .TIMER_DIGITS(TD),
        .GAME_SECONDS(SAT_GS), .TICK_DIV(SAT_TDIV), .REFRESH_DIV(RDIV)) dut_sat (
        .clock(clock), .reset(reset), .increment_score(sat_inc),
        .start_game(sat_start), .anode_activate(sat_anode),
        .LED_out(sat_led), .game_active(sat_active));

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] bcd4(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] exp_seg(input int pos);
        int shown;
        shown = (HS_EN && m_state == M_IDLE) ? m_high : m_score;
        if (pos >= ND - TD) return SEG_TB[(m_timer / pow10(pos - (ND - TD))) % 10];
        else if (pos < SD) return SEG_TB[(shown / pow10(pos)) % 10];
        else return 8'hFF;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_score = 0; m_timer = GS; m_tick = 0; m_high = 0; m_edges = 0;
        h0 = 0; h1 = 0; h2 = 0;
    endtask

    // One clock: drive at negedge, advance model at posedge, compare at next negedge
    task automatic tick(input bit inc, input bit st);
        logic [ND-1:0] e_an;
        logic [7:0]    e_led;
        bit            pulse;
        increment_score = inc;
        start_game      = st;
        @(posedge clock);
        e_an  = ~(ND'(1) << ((m_edges / RDIV) % ND));
        e_led = exp_seg((m_edges / RDIV) % ND);
        pulse = h1 & ~h2;
        h2 = h1; h1 = h0; h0 = inc;
        if (m_state != M_PLAY && st) begin
            m_state = M_PLAY; m_score = 0; m_timer = GS; m_tick = 0;
        end else if (m_state == M_PLAY) begin
            if (pulse && m_score < 9999) m_score++;
            m_tick++;
            if (m_tick == TDIV) begin
                m_tick = 0;
                m_timer--;
                if (m_timer == 0) begin
                    m_state = M_OVER;
                    if (m_score > m_high) m_high = m_score;
                end
            end
        end
        m_edges++;
        @(negedge clock);
        checks++;
        if (game_active !== (m_state == M_PLAY)) begin
            errors++;
            $display("FAIL game_active edge %0d: got %b expected %b", m_edges, game_active, m_state == M_PLAY);
        end
        checks++;
        if (anode_activate !== e_an) begin
            errors++;
            $display("FAIL anode edge %0d: got %h expected %h", m_edges, anode_activate, e_an);
        end
        checks++;
        if (LED_out !== e_led) begin
            errors++;
            $display("FAIL led edge %0d: got %h expected %h", m_edges, LED_out, e_led);
        end
        checks++;
        if (dut.score_q !== bcd4(m_score)) begin
            errors++;
            $display("FAIL score edge %0d: got %h expected %h", m_edges, dut.score_q, bcd4(m_score));
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; increment_score = 0; start_game = 0; sat_inc = 0; sat_start = 0;
        #1;
        checks++;
        if (anode_activate !== 8'hFE || LED_out !== 8'hFF || game_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got an=%h led=%h act=%b expected an=fe led=ff act=0",
                     anode_activate, LED_out, game_active);
        end
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (anode_activate !== 8'hFE || LED_out !== 8'hFF || game_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: got an=%h led=%h act=%b expected an=fe led=ff act=0",
                     anode_activate, LED_out, game_active);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic scan_main();
        for (int c = 0; c < 36; c++) begin
            tick(1'b0, 1'b0);
            for (int p = 0; p < ND; p++)
                if (anode_activate == ~(ND'(1) << p)) disp[p] = LED_out;
        end
    endtask

    task automatic finish_round();
        for (int c = 0; c < 40 && m_state == M_PLAY; c++) tick(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 40; c++) tick(1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic test_round();
        tick(1'b0, 1'b1);
        checks++;
        if (game_active !== 1'b1) begin
            errors++; $display("FAIL round_start: got %b expected 1", game_active);
        end
        for (int c = 0; c < 30; c++) tick(1'b0, 1'b0);
        checks++;
        if (game_active !== 1'b0) begin
            errors++; $display("FAIL round_expire: got %b expected 0", game_active);
        end
        scan_main();
        checks++;
        if (disp[7] !== SEG_TB[0] || disp[6] !== SEG_TB[0]) begin
            errors++; $display("FAIL timer_zero_display: got %h %h expected c0 c0", disp[7], disp[6]);
        end
    endtask

    task automatic test_increment();
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        checks++;
        if (dut.score_q !== 16'h0000) begin
            errors++; $display("FAIL inc_latency_early: got %h expected 0000", dut.score_q);
        end
        tick(1'b1, 1'b0);
        checks++;
        if (dut.score_q !== 16'h0001) begin
            errors++; $display("FAIL inc_latency_third: got %h expected 0001", dut.score_q);
        end
        for (int c = 0; c < 17; c++) tick(1'b1, 1'b0);
        checks++;
        if (dut.score_q !== 16'h0001) begin
            errors++; $display("FAIL inc_hold: got %h expected 0001", dut.score_q);
        end
        tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0);
        checks++;
        if (dut.score_q !== 16'h0002) begin
            errors++; $display("FAIL inc_second: got %h expected 0002", dut.score_q);
        end
        finish_round();
    endtask

    task automatic test_gating();
        for (int c = 0; c < 20; c++) tick(1'($urandom_range(0, 1)), 1'b0);
        checks++;
        if (dut.score_q !== 16'h0002) begin
            errors++; $display("FAIL gameover_gating: got %h expected 0002", dut.score_q);
        end
        tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        for (int e = 1; e <= 30; e++) tick(e >= 28, 1'b0);
        checks++;
        if (dut.score_q !== 16'h0001 || game_active !== 1'b0) begin
            errors++;
            $display("FAIL expiry_point: got score=%h act=%b expected score=0001 act=0", dut.score_q, game_active);
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b1);
        checks++;
        if (dut.score_q !== 16'h0000 || game_active !== 1'b1) begin
            errors++;
            $display("FAIL start_with_pulse: got score=%h act=%b expected score=0000 act=1", dut.score_q, game_active);
        end
        tick(1'b0, 1'b0);
        finish_round();
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            tick(1'b0, 1'b1);
            for (int c = 0; c < 36; c++)
                tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
            for (int c = 0; c < 6; c++) tick(1'b0, 1'b0);
        end
    endtask

`ifdef CLAWGAME_HIGH_SCORE_EN
    task automatic test_high_score();
        do_reset();
        scan_main();
        checks++;
        if (disp[0] !== SEG_TB[0]) begin
            errors++; $display("FAIL idle_high_zero: got %h expected c0", disp[0]);
        end
        tick(1'b0, 1'b1);
        for (int e = 0; e < 10; e++) tick(e % 2 == 0, 1'b0);
        finish_round();
        tick(1'b0, 1'b1);
        for (int e = 0; e < 4; e++) tick(e % 2 == 0, 1'b0);
        finish_round();
        scan_main();
        checks++;
        if (disp[0] !== SEG_TB[2] || disp[1] !== SEG_TB[0]) begin
            errors++; $display("FAIL gameover_current: got %h%h expected c0 a4", disp[1], disp[0]);
        end
        checks++;
        if (dut.high_score_q !== 16'h0005) begin
            errors++; $display("FAIL high_score: got %h expected 0005", dut.high_score_q);
        end
    endtask
`endif

    task automatic test_mid_reset();
        tick(1'b0, 1'b1);
        for (int c = 0; c < 8; c++) tick(c % 2 == 0, 1'b0);
        tick(1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (game_active !== 1'b0 || anode_activate !== 8'hFE || LED_out !== 8'hFF || dut.score_q !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset: got act=%b an=%h led=%h score=%h expected 0 fe ff 0000",
                     game_active, anode_activate, LED_out, dut.score_q);
        end
        @(negedge clock);
        reset = 1'b0;
        increment_score = 1'b0;
        model_reset();
        for (int c = 0; c < 12; c++) tick(1'b0, 1'b0);
    endtask

    task automatic check_sat_display(input int value);
        for (int c = 0; c < 36; c++) begin
            @(negedge clock);
            for (int p = 0; p < ND; p++)
                if (sat_anode == ~(ND'(1) << p)) disp[p] = sat_led;
        end
        for (int p = 0; p < 6; p++) begin
            checks++;
            if (disp[p] !== ((p < SD) ? SEG_TB[(value / pow10(p)) % 10] : 8'hFF)) begin
                errors++;
                $display("FAIL sat_digit%0d: got %h expected %h", p, disp[p],
                         (p < SD) ? SEG_TB[(value / pow10(p)) % 10] : 8'hFF);
            end
        end
        checks++;
        if (sat_active !== 1'b1) begin
            errors++; $display("FAIL sat_active: got %b expected 1", sat_active);
        end
    endtask

    task automatic test_saturation();
        sat_start = 1'b1;
        @(negedge clock);
        sat_start = 1'b0;
        for (int i = 0; i < 9998; i++) begin
            sat_inc = 1'b1; @(negedge clock);
            sat_inc = 1'b0; @(negedge clock);
        end
        repeat (4) @(negedge clock);
        check_sat_display(9998);
        for (int i = 0; i < 3; i++) begin
            sat_inc = 1'b1; @(negedge clock);
            sat_inc = 1'b0; @(negedge clock);
        end
        repeat (4) @(negedge clock);
        check_sat_display(9999);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_round();
        test_increment();
        test_gating();
        test_back_to_back();
        test_random();
`ifdef CLAWGAME_HIGH_SCORE_EN
        test_high_score();
`endif
        test_mid_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
